// File: rtl/serial_feeder.sv
// serial_feeder: parallel-to-serial front end for the sequence-detection path.
// Accepts a WIDTH-bit word on a valid/ready handshake and shifts it out
// MSB-first, one bit per clock. Every output is a flop.
// Optional feature macro: SERIAL_FEEDER_PARITY_EN (appends an even-parity bit).
//
// state  | meaning
// IDLE   | line at 0, ready high once out of reset, waiting for load
// SHIFT  | data bits on serialOutput, counter tracks the bit on the line
// PARITY | one even-parity bit after bit 0 (parity builds only)

module serial_feeder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load,
  output logic             ready,
  output logic             serialOutput,
  output logic             bit_valid,
  output logic             frame_done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef SERIAL_FEEDER_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
  logic parity_q;
`else
  typedef enum logic {IDLE, SHIFT} state_t;
  localparam logic [CW-1:0] PENULT = CW'(WIDTH - 2);
`endif

  state_t           state;
  logic [WIDTH-1:0] shift_reg;
  logic [CW-1:0]    cnt;

  // Frame sequencer. The MSB is driven straight from data_in at the accept
  // edge, so shift_reg holds the bits still to come and cnt is the index of
  // the bit currently on the line.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      shift_reg    <= '0;
      cnt          <= '0;
      ready        <= 1'b0;
      serialOutput <= 1'b0;
      bit_valid    <= 1'b0;
      frame_done   <= 1'b0;
`ifdef SERIAL_FEEDER_PARITY_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          serialOutput <= 1'b0;
          bit_valid    <= 1'b0;
          frame_done   <= 1'b0;
          if (load && ready) begin
            state        <= SHIFT;
            shift_reg    <= {data_in[WIDTH-2:0], 1'b0};
            cnt          <= '0;
            ready        <= 1'b0;
            serialOutput <= data_in[WIDTH-1];
            bit_valid    <= 1'b1;
`ifdef SERIAL_FEEDER_PARITY_EN
            parity_q     <= ^data_in;
`endif
          end else begin
            ready <= 1'b1;
          end
        end

        SHIFT: begin
          if (cnt == LAST) begin
`ifdef SERIAL_FEEDER_PARITY_EN
            state        <= PARITY;
            serialOutput <= parity_q;
            bit_valid    <= 1'b1;
            frame_done   <= 1'b1;
`else
            state        <= IDLE;
            serialOutput <= 1'b0;
            bit_valid    <= 1'b0;
            frame_done   <= 1'b0;
            ready        <= 1'b1;
`endif
          end else begin
            serialOutput <= shift_reg[WIDTH-1];
            shift_reg    <= {shift_reg[WIDTH-2:0], 1'b0};
            cnt          <= cnt + 1'b1;
            bit_valid    <= 1'b1;
`ifdef SERIAL_FEEDER_PARITY_EN
            frame_done   <= 1'b0;
`else
            // Pulse lands on the cycle that carries bit 0.
            frame_done   <= (cnt == PENULT);
`endif
          end
        end

`ifdef SERIAL_FEEDER_PARITY_EN
        PARITY: begin
          state        <= IDLE;
          serialOutput <= 1'b0;
          bit_valid    <= 1'b0;
          frame_done   <= 1'b0;
          ready        <= 1'b1;
        end
`endif

        default: begin
          state        <= IDLE;
          serialOutput <= 1'b0;
          bit_valid    <= 1'b0;
          frame_done   <= 1'b0;
          ready        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_feeder.sv
// Self-checking bench for serial_feeder. Expected streams come from the word
// bits and a popcount-based parity; each cycle the vector
// {ready, bit_valid, frame_done, serialOutput} is compared.
`timescale 1ns/1ps

module tb_serial_feeder;

  localparam int W = 8;
`ifdef SERIAL_FEEDER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FL = W + PAR;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] data_in;
  logic         load;
  logic         ready;
  logic         serialOutput;
  logic         bit_valid;
  logic         frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  serial_feeder #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .data_in      (data_in),
    .load         (load),
    .ready        (ready),
    .serialOutput (serialOutput),
    .bit_valid    (bit_valid),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  // Bit i (1-based) of a frame: data MSB-first, then even parity if enabled.
  function automatic logic model_bit(logic [W-1:0] w, int i);
    if (i <= W) return w[W-i];
    return ($countones(w) % 2) == 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int k = 0;
    while (ready !== 1'b1 && k < 30) begin
      tick();
      k++;
    end
    n_checks++;
    if (ready !== 1'b1) begin
      n_fail++;
      $display("FAIL wait_ready: ready=%b required 1 within 30 cycles", ready);
    end
  endtask

  task automatic test_reset();
    logic [3:0] obs;
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      obs = {ready, bit_valid, frame_done, serialOutput};
      n_checks++;
      if (obs !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset_hold c%0d: {rdy,bv,fd,so}=%b required 0000", c, obs);
      end
    end
    reset = 1'b0;
    tick();
    obs = {ready, bit_valid, frame_done, serialOutput};
    n_checks++;
    if (obs !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_release: {rdy,bv,fd,so}=%b required 1000", obs);
    end
  endtask

  task automatic test_frame(input logic [W-1:0] word, input string name);
    logic [3:0] obs, exp;
    wait_ready();
    load    = 1'b1;
    data_in = word;
    tick();
    load    = 1'b0;
    data_in = W'($urandom);
    for (int i = 1; i <= FL; i++) begin
      exp = {1'b0, 1'b1, (i == FL), model_bit(word, i)};
      obs = {ready, bit_valid, frame_done, serialOutput};
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL %s word=%h bit%0d: {rdy,bv,fd,so}=%b required %b", name, word, i, obs, exp);
      end
      tick();
    end
    obs = {ready, bit_valid, frame_done, serialOutput};
    n_checks++;
    if (obs !== 4'b1000) begin
      n_fail++;
      $display("FAIL %s word=%h after: {rdy,bv,fd,so}=%b required 1000", name, word, obs);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] w;
    for (int n = 0; n < 8; n++) begin
      w = W'($urandom);
      repeat ($urandom_range(0, 3)) tick();
      test_frame(w, "random");
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] obs, exp;
    logic [W-1:0] w1 = 8'hFF;
    logic [W-1:0] w2 = 8'h00;
    wait_ready();
    load    = 1'b1;
    data_in = w1;
    tick();
    data_in = w2;
    for (int c = 1; c <= 2*FL + 2; c++) begin
      if (c <= FL)
        exp = {1'b0, 1'b1, (c == FL), model_bit(w1, c)};
      else if (c == FL + 1)
        exp = 4'b1000;
      else if (c <= 2*FL + 1)
        exp = {1'b0, 1'b1, (c == 2*FL + 1), model_bit(w2, c - FL - 1)};
      else
        exp = 4'b1000;
      obs = {ready, bit_valid, frame_done, serialOutput};
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL back_to_back c%0d: {rdy,bv,fd,so}=%b required %b", c, obs, exp);
      end
      if (c == FL + 2) load = 1'b0;
      tick();
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [3:0] obs, exp;
    logic [W-1:0] w = 8'hF0;
    wait_ready();
    load    = 1'b1;
    data_in = w;
    tick();
    load = 1'b0;
    for (int i = 1; i <= 2; i++) begin
      exp = {1'b0, 1'b1, 1'b0, model_bit(w, i)};
      obs = {ready, bit_valid, frame_done, serialOutput};
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL reset_mid pre bit%0d: {rdy,bv,fd,so}=%b required %b", i, obs, exp);
      end
      if (i == 2) begin
        reset = 1'b1;
        load  = 1'b1;
      end
      tick();
    end
    obs = {ready, bit_valid, frame_done, serialOutput};
    n_checks++;
    if (obs !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_mid abort: {rdy,bv,fd,so}=%b required 0000", obs);
    end
    load  = 1'b0;
    reset = 1'b0;
    for (int c = 0; c < W + 2; c++) begin
      tick();
      obs = {ready, bit_valid, frame_done, serialOutput};
      n_checks++;
      if (obs !== 4'b1000) begin
        n_fail++;
        $display("FAIL reset_mid after c%0d: {rdy,bv,fd,so}=%b required 1000", c, obs);
      end
    end
  endtask

  task automatic test_load_while_busy();
    logic [3:0] obs, exp;
    logic [W-1:0] w = W'($urandom) ^ 8'h5A;
    wait_ready();
    load    = 1'b1;
    data_in = w;
    tick();
    load = 1'b0;
    for (int i = 1; i <= FL; i++) begin
      exp = {1'b0, 1'b1, (i == FL), model_bit(w, i)};
      obs = {ready, bit_valid, frame_done, serialOutput};
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL busy_load word=%h bit%0d: {rdy,bv,fd,so}=%b required %b", w, i, obs, exp);
      end
      if (i == 3) begin
        load    = 1'b1;
        data_in = 8'h3C;
      end
      if (i == 4) load = 1'b0;
      tick();
    end
    for (int c = 0; c < 5; c++) begin
      obs = {ready, bit_valid, frame_done, serialOutput};
      n_checks++;
      if (obs !== 4'b1000) begin
        n_fail++;
        $display("FAIL busy_load idle c%0d: {rdy,bv,fd,so}=%b required 1000", c, obs);
      end
      tick();
    end
  endtask

  initial begin
    reset   = 1'b1;
    load    = 1'b0;
    data_in = '0;
    test_reset();
    test_frame(8'hA5, "frame_a5");
    test_frame(8'h07, "frame_07");
    test_random();
    test_back_to_back();
    test_reset_mid_frame();
    test_load_while_busy();
    repeat (2) tick();
    test_reset();
    test_frame(8'h81, "frame_81");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
